// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 8;

endpackage

// File: rtl/seq_multiplier_adder.sv
// N-bit adder with carry in/out; its carry out becomes the top bit of the
// multiplier's right-shifted accumulator.
module adder_n_bit #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c_in,
    output logic [N-1:0] o_sum,
    output logic         o_c_out
);

    assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c_in};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
// Define SEQ_MULTIPLIER_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are zero.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_y;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_product;
    logic [CW-1:0]  r_cnt;

    logic [N-1:0]   w_addend;
    logic [N-1:0]   w_sum;
    logic           w_c_out;
    logic [2*N-1:0] w_acc_next;
    logic [2*N-1:0] w_result;
    logic [CW-1:0]  w_cnt_next;
    logic           w_early;
    logic           w_y_zero;

    assign w_addend = r_y[0] ? r_x : '0;

    adder_n_bit #(.N(N)) u_adder (
        .i_a     (r_acc[2*N-1:N]),
        .i_b     (w_addend),
        .i_c_in  (1'b0),
        .o_sum   (w_sum),
        .o_c_out (w_c_out)
    );

    assign w_acc_next = {w_c_out, w_sum, r_acc[N-1:1]};
    assign w_cnt_next = r_cnt + 1'b1;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    logic [CW-1:0] w_shamt;

    // Skipped zero bits would only shift, so apply the remaining shift at once.
    assign w_y_zero = (y == '0);
    assign w_early  = (r_y[N-1:1] == '0);
    assign w_shamt  = CNT_LAST - w_cnt_next;
    assign w_result = w_acc_next >> w_shamt;
`else
    assign w_y_zero = 1'b0;
    assign w_early  = 1'b0;
    assign w_result = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = w_y_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if ((w_cnt_next == CNT_LAST) || w_early) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x   <= x;
                        r_y   <= y;
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (w_y_zero) begin
                            r_product <= '0;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_y   <= r_y >> 1;
                    r_cnt <= w_cnt_next;
                    if (w_state_next == DONE) begin
                        r_product <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: N=8 and N=4 instances checked every cycle against a
// cycle-count/arithmetic model, plus directed literal checks and an N=4 sweep.
module tb_seq_multiplier;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s8 = 1'b0;
    logic [7:0]  x8 = '0;
    logic [7:0]  y8 = '0;
    logic        r8, d8;
    logic [15:0] p8;
    logic        s4 = 1'b0;
    logic [3:0]  x4 = '0;
    logic [3:0]  y4 = '0;
    logic        r4, d4;
    logic [7:0]  p4;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    bit     m_valid = 1'b0;
    longint m_done_at [2];
    longint m_pend [2];
    longint m_prod [2];
    int     dcnt [2];
    longint last_p [2];

    seq_multiplier #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .x(x8), .y(y8),
        .ready(r8), .done(d8), .product(p8)
    );

    seq_multiplier #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .x(x4), .y(y4),
        .ready(r4), .done(d4), .product(p4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", nm, got, got, want, want, cyc);
        end
    endtask

    // Edges from acceptance to the done cycle.
    function automatic int lat_of(input int w, input int yv);
        int l;
        l = w;
        if (EE) begin
            l = 0;
            for (int b = 0; b < w; b++) begin
                if (yv[b]) l = b + 1;
            end
        end
        return l;
    endfunction

    task automatic model_update(input int i, input logic st, input int xv, input int yv, input int w);
        if (!rst_n) begin
            m_done_at[i] = -100;
            m_prod[i]    = 0;
            m_valid      = 1'b1;
        end else begin
            if (st && (cyc - 1 > m_done_at[i])) begin
                m_pend[i]    = longint'(xv) * longint'(yv);
                m_done_at[i] = cyc + lat_of(w, yv);
            end
            if (cyc == m_done_at[i]) m_prod[i] = m_pend[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_update(0, s8, int'(x8), int'(y8), 8);
        model_update(1, s4, int'(x4), int'(y4), 4);
        #1;
        if (m_valid) begin
            chk("ready8", r8, cyc > m_done_at[0]);
            chk("done8", d8, cyc == m_done_at[0]);
            chk("product8", p8, m_prod[0]);
            chk("ready4", r4, cyc > m_done_at[1]);
            chk("done4", d4, cyc == m_done_at[1]);
            chk("product4", p4, m_prod[1]);
        end
        if (d8) begin dcnt[0]++; last_p[0] = p8; end
        if (d4) begin dcnt[1]++; last_p[1] = p4; end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait expired at cycle %0d", nm, cyc);
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        while (!(cyc > m_done_at[0]) && n < 40) begin tick(); n++; end
        if (n >= 40) timeout("idle8");
    endtask

    task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input bit scramble, output int lat);
        int n;
        int acc;
        wait_idle8();
        s8 = 1'b1; x8 = xa; y8 = ya;
        tick();
        s8 = 1'b0;
        acc = cyc;
        lat = d8 ? 0 : -1;
        n = 0;
        while (lat < 0 && n < 40) begin
            if (scramble) begin
                x8 = 8'($urandom); y8 = 8'($urandom); s8 = 1'($urandom);
            end
            tick();
            n++;
            if (d8) lat = cyc - acc;
        end
        s8 = 1'b0;
        if (lat < 0) timeout("run_op");
    endtask

    initial begin
        int lat;
        int d0;
        int n;
        m_done_at[0] = -100; m_done_at[1] = -100;
        m_prod[0] = 0; m_prod[1] = 0; m_pend[0] = 0; m_pend[1] = 0;
        dcnt[0] = 0; dcnt[1] = 0; last_p[0] = 0; last_p[1] = 0;

        rst_n = 1'b0;
        tick(); tick();
        chk("reset_ready8", r8, 1);
        chk("reset_done8", d8, 0);
        chk("reset_product8", p8, 0);
        rst_n = 1'b1;
        tick();

        run_op(8'd255, 8'd255, 1'b0, lat);
        chk("ff_latency", lat, 8);
        chk("ff_product", last_p[0], 16'hFE01);
        $display("op x=255 y=255 lat=%0d product=%0h", lat, last_p[0]);

        run_op(8'd13, 8'd11, 1'b1, lat);
        chk("scramble_latency", lat, EE ? 4 : 8);
        chk("scramble_product", last_p[0], 143);
        $display("op x=13 y=11 lat=%0d product=%0d", lat, last_p[0]);

        wait_idle8();
        d0 = dcnt[0];
        s8 = 1'b1; x8 = 8'd2; y8 = 8'd3;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (d8) chk("hold_product", p8, 6);
        end
        s8 = 1'b0;
        chk("hold_dones", dcnt[0] - d0, EE ? 10 : 4);
        $display("held start x=2 y=3 dones=%0d", dcnt[0] - d0);

        wait_idle8();
        s8 = 1'b1; x8 = 8'd100; y8 = 8'd50;
        tick();
        s8 = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_ready", r8, 1);
        chk("abort_product", p8, 0);
        d0 = dcnt[0];
        for (int k = 0; k < 12; k++) tick();
        chk("abort_no_done", dcnt[0] - d0, 0);
        $display("abort x=100 y=50 dones=%0d product=%0d", dcnt[0] - d0, p8);

        run_op(8'd7, 8'd0, 1'b0, lat);
        chk("y0_latency", lat, EE ? 0 : 8);
        chk("y0_product", last_p[0], 0);
        $display("op x=7 y=0 lat=%0d product=%0d", lat, last_p[0]);
        run_op(8'd7, 8'd1, 1'b0, lat);
        chk("y1_latency", lat, EE ? 1 : 8);
        chk("y1_product", last_p[0], 7);
        $display("op x=7 y=1 lat=%0d product=%0d", lat, last_p[0]);

        for (int k = 0; k < 300; k++) begin
            rst_n = ($urandom_range(0, 60) != 0);
            s8 = ($urandom_range(0, 3) == 0);
            x8 = 8'($urandom); y8 = 8'($urandom);
            s4 = 1'($urandom);
            x4 = 4'($urandom); y4 = 4'($urandom);
            tick();
        end
        rst_n = 1'b1; s8 = 1'b0; s4 = 1'b0;
        $display("random phase done at cycle %0d", cyc);

        d0 = dcnt[1];
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                n = 0;
                while (!(cyc > m_done_at[1]) && n < 20) begin tick(); n++; end
                if (n >= 20) timeout("idle4");
                s4 = 1'b1; x4 = 4'(a); y4 = 4'(b);
                tick();
                s4 = 1'b0;
            end
        end
        n = 0;
        while (!(cyc > m_done_at[1]) && n < 20) begin tick(); n++; end
        if (n >= 20) timeout("sweep_end");
        chk("sweep_dones", dcnt[1] - d0, 256);
        $display("sweep N=4 dones=%0d", dcnt[1] - d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
